// File: rtl/ifu_fetch_if.sv
// Fetch-unit bus bundle: AXI4-Lite read channel (AR/R), decode handshake and write-back next-PC.
// master = fetch unit; slave = the memory / decode / write-back side.
interface ifu_fetch_if #(
  parameter int WIDTH = 32
);
  // AXI4-Lite read address / read data
  logic [WIDTH-1:0] araddr;
  logic             arvalid;
  logic             arready;
  logic [31:0]      rdata;
  logic [1:0]       rresp;
  logic             rvalid;
  logic             rready;

  // Decode handshake
  logic [31:0]      inst;
  logic [WIDTH-1:0] inst_pc;
  logic             inst_fault;
  logic             inst_valid;
  logic             inst_ready;

  // Write-back redirect
  logic [WIDTH-1:0] next_pc;
  logic             next_pc_valid;

  modport master (
    output araddr, arvalid, rready,
    output inst, inst_pc, inst_fault, inst_valid,
    input  arready, rdata, rresp, rvalid,
    input  inst_ready, next_pc, next_pc_valid
  );

  modport slave (
    input  araddr, arvalid, rready,
    input  inst, inst_pc, inst_fault, inst_valid,
    output arready, rdata, rresp, rvalid,
    output inst_ready, next_pc, next_pc_valid
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one AXI4-Lite read per instruction, one instruction in flight.
// Optional macro IFU_MISALIGN_CHECK_EN: a PC with pc[1:0]!=0 faults without issuing a read.
module ifu_fetch #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic         clk,
  input  logic         rst,
  ifu_fetch_if.master  bus
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_RESP = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] pc;
  logic             arvalid;
  logic             rready;
  logic [31:0]      inst;
  logic [WIDTH-1:0] inst_pc;
  logic             inst_fault;
  logic             inst_valid;

  logic             pc_misaligned;
  logic             next_pc_misaligned;

`ifdef IFU_MISALIGN_CHECK_EN
  assign pc_misaligned      = |pc[1:0];
  assign next_pc_misaligned = |bus.next_pc[1:0];
`else
  assign pc_misaligned      = 1'b0;
  assign next_pc_misaligned = 1'b0;
`endif

  // Handshake outputs are flops, so nothing combinational reaches arvalid/inst_valid
  // and a reset asserted mid-transaction drops them on the very next cycle.
  // NOTE: all state here is written with non-blocking assignments so every branch
  // reads the pre-edge values; blocking assignments would make the order of the
  // statements change the hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      inst       <= 32'h0;
      inst_pc    <= RESET_PC;
      inst_fault <= 1'b0;
      inst_valid <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (arvalid) begin
            if (bus.arready) begin
              arvalid <= 1'b0;
              rready  <= 1'b1;
              state   <= S_RESP;
            end
          end else if (pc_misaligned) begin
            inst       <= 32'h0;
            inst_pc    <= pc;
            inst_fault <= 1'b1;
            inst_valid <= 1'b1;
            state      <= S_OUT;
          end else begin
            // First cycle after reset: the request goes out one cycle after release.
            arvalid <= 1'b1;
          end
        end

        S_RESP: begin
          if (bus.rvalid) begin
            rready     <= 1'b0;
            inst       <= bus.rdata;
            inst_pc    <= pc;
            inst_fault <= (bus.rresp != 2'b00);
            inst_valid <= 1'b1;
            state      <= S_OUT;
          end
        end

        S_OUT: begin
          if (bus.inst_ready) begin
            inst_valid <= 1'b0;
            state      <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (bus.next_pc_valid) begin
            pc      <= bus.next_pc;
            arvalid <= !next_pc_misaligned;
            state   <= S_REQ;
          end
        end

        default: state <= S_REQ;
      endcase
    end
  end

  assign bus.araddr     = pc;
  assign bus.arvalid    = arvalid;
  assign bus.rready     = rready;
  assign bus.inst       = inst;
  assign bus.inst_pc    = inst_pc;
  assign bus.inst_fault = inst_fault;
  assign bus.inst_valid = inst_valid;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: reset, fetch latency, backpressure, redirect, AR stall,
// error response, reset mid-fetch and misaligned redirect (both builds).
module tb_ifu_fetch;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  ifu_fetch_if #(.WIDTH(32)) bus ();

  ifu_fetch #(.WIDTH(32), .RESET_PC(32'h8000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      passed++;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst               = 1'b1;
    bus.arready       = 1'b0;
    bus.rdata         = 32'h0;
    bus.rresp         = 2'b00;
    bus.rvalid        = 1'b0;
    bus.inst_ready    = 1'b0;
    bus.next_pc       = 32'h0;
    bus.next_pc_valid = 1'b0;
    step();
    step();

    // Reset state
    check("rst_arvalid", 32'(bus.arvalid), 32'd0);
    check("rst_rready", 32'(bus.rready), 32'd0);
    check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    check("rst_inst_fault", 32'(bus.inst_fault), 32'd0);
    check("rst_inst", bus.inst, 32'h0);

    // 1: first fetch after reset, minimum latency
    rst = 1'b0;
    step();
    check("t1_arvalid", 32'(bus.arvalid), 32'd1);
    check("t1_araddr", bus.araddr, 32'h8000_0000);
    bus.arready = 1'b1;
    bus.rvalid  = 1'b1;
    bus.rdata   = 32'h0010_0093;
    step();
    check("t1_ar_done", 32'(bus.arvalid), 32'd0);
    check("t1_rready", 32'(bus.rready), 32'd1);
    check("t1_not_yet_valid", 32'(bus.inst_valid), 32'd0);
    step();
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    check("t1_inst_valid", 32'(bus.inst_valid), 32'd1);
    check("t1_inst", bus.inst, 32'h0010_0093);
    check("t1_inst_pc", bus.inst_pc, 32'h8000_0000);
    check("t1_fault", 32'(bus.inst_fault), 32'd0);
    check("t1_rready_off", 32'(bus.rready), 32'd0);

    // 2: decode backpressure
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_hold_valid", 32'(bus.inst_valid), 32'd1);
      check("t2_hold_inst", bus.inst, 32'h0010_0093);
      check("t2_hold_pc", bus.inst_pc, 32'h8000_0000);
    end
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    check("t2_released", 32'(bus.inst_valid), 32'd0);

    // S_WAIT: no new request until write-back supplies next_pc
    step();
    check("wait_no_ar", 32'(bus.arvalid), 32'd0);

    // 3: redirect, AR stalled 3 cycles; rvalid during S_REQ is ignored
    bus.next_pc       = 32'h8000_0010;
    bus.next_pc_valid = 1'b1;
    step();
    bus.next_pc_valid = 1'b0;
    bus.next_pc       = 32'h0;
    bus.rvalid        = 1'b1;
    bus.rdata         = 32'h1111_1111;
    check("t3_arvalid", 32'(bus.arvalid), 32'd1);
    check("t3_araddr", bus.araddr, 32'h8000_0010);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_stall_arvalid", 32'(bus.arvalid), 32'd1);
      check("t3_stall_araddr", bus.araddr, 32'h8000_0010);
      check("t3_stall_rready", 32'(bus.rready), 32'd0);
    end
    bus.rvalid  = 1'b0;
    bus.arready = 1'b1;
    step();
    bus.arready = 1'b0;
    check("t3_ar_done", 32'(bus.arvalid), 32'd0);
    check("t3_rready", 32'(bus.rready), 32'd1);
    step();
    check("t3_r_wait", 32'(bus.rready), 32'd1);
    check("t3_r_wait_valid", 32'(bus.inst_valid), 32'd0);

    // 4: error response still delivered, flagged as fault
    bus.rvalid = 1'b1;
    bus.rresp  = 2'b10;
    bus.rdata  = 32'hdead_beef;
    step();
    bus.rvalid = 1'b0;
    bus.rresp  = 2'b00;
    check("t4_valid", 32'(bus.inst_valid), 32'd1);
    check("t4_fault", 32'(bus.inst_fault), 32'd1);
    check("t4_inst", bus.inst, 32'hdead_beef);
    check("t4_pc", bus.inst_pc, 32'h8000_0010);
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    check("t4_released", 32'(bus.inst_valid), 32'd0);

    // 5: reset while waiting for the R beat
    bus.next_pc       = 32'h8000_0020;
    bus.next_pc_valid = 1'b1;
    step();
    bus.next_pc_valid = 1'b0;
    check("t5_araddr", bus.araddr, 32'h8000_0020);
    bus.arready = 1'b1;
    step();
    bus.arready = 1'b0;
    check("t5_in_resp", 32'(bus.rready), 32'd1);
    rst = 1'b1;
    step();
    check("t5_rst_arvalid", 32'(bus.arvalid), 32'd0);
    check("t5_rst_rready", 32'(bus.rready), 32'd0);
    check("t5_rst_valid", 32'(bus.inst_valid), 32'd0);
    rst = 1'b0;
    step();
    check("t5_restart_arvalid", 32'(bus.arvalid), 32'd1);
    check("t5_restart_araddr", bus.araddr, 32'h8000_0000);
    bus.arready = 1'b1;
    step();
    bus.arready = 1'b0;
    bus.rvalid  = 1'b1;
    bus.rdata   = 32'h0000_0013;
    step();
    bus.rvalid = 1'b0;
    check("t5_inst", bus.inst, 32'h0000_0013);
    check("t5_inst_pc", bus.inst_pc, 32'h8000_0000);
    check("t5_fault", 32'(bus.inst_fault), 32'd0);
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;

    // 6: misaligned redirect
    bus.next_pc       = 32'h8000_0002;
    bus.next_pc_valid = 1'b1;
    step();
    bus.next_pc_valid = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
    check("t6_no_arvalid", 32'(bus.arvalid), 32'd0);
    step();
    check("t6_no_arvalid2", 32'(bus.arvalid), 32'd0);
    check("t6_valid", 32'(bus.inst_valid), 32'd1);
    check("t6_fault", 32'(bus.inst_fault), 32'd1);
    check("t6_inst", bus.inst, 32'h0);
    check("t6_pc", bus.inst_pc, 32'h8000_0002);
`else
    check("t6_arvalid", 32'(bus.arvalid), 32'd1);
    check("t6_araddr", bus.araddr, 32'h8000_0002);
    bus.arready = 1'b1;
    step();
    bus.arready = 1'b0;
    bus.rvalid  = 1'b1;
    bus.rdata   = 32'h0000_0abc;
    step();
    bus.rvalid = 1'b0;
    check("t6_valid", 32'(bus.inst_valid), 32'd1);
    check("t6_fault", 32'(bus.inst_fault), 32'd0);
    check("t6_inst", bus.inst, 32'h0000_0abc);
    check("t6_pc", bus.inst_pc, 32'h8000_0002);
`endif
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    check("t6_released", 32'(bus.inst_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
